ear_in_conditioner: RTL

EAR_IN_CONDITIONER -- requirements
Module: ear_in_conditioner

---
 rtl/ear_in_conditioner.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ear_in_conditioner.sv
// ear_in_conditioner -- conditions the asynchronous tape EAR line.
//
// Synchronizes the raw level, rejects glitches shorter than FILT_LEN cycles,
// strobes each accepted transition, drives a retriggerable activity
// indicator, and optionally measures the spacing between accepted edges.
//
// Optional feature macro: EAR_PULSE_STATS_EN
//   defined   -> edge-to-edge timing FSM, pulse_width and pulse_valid are built
//   undefined -> pulse_width/pulse_valid tied to 0, clr_stats ignored
//
// Ports
//   clk          CPU clock, all logic on rising edge
//   nreset       asynchronous active-low reset
//   ear_raw      asynchronous tape line-in level
//   clr_stats    single-cycle request to drop the pulse-timing reference
//   ear_out      filtered EAR level (port-FE bit 6)
//   ear_edge     one-cycle strobe on every accepted transition of ear_out
//                ("edge" is a reserved word in SystemVerilog)
//   pulse_width  cycles between the last two accepted edges, saturating
//   pulse_valid  one-cycle strobe marking a new pulse_width
//   activity     tape-loading LED indicator
module ear_in_conditioner #(
    parameter int FILT_LEN = 8,
    parameter int ACT_HOLD = 350000,
    parameter bit INVERT   = 1'b0
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        ear_raw,
    input  logic        clr_stats,
    output logic        ear_out,
    output logic        ear_edge,
    output logic [15:0] pulse_width,
    output logic        pulse_valid,
    output logic        activity
);

    localparam logic [7:0]  FC_LAST = 8'(FILT_LEN - 1);
    localparam logic [19:0] AT_LOAD = 20'(ACT_HOLD);

    logic       sync0, sync1;
    logic [7:0] fc;
    logic [19:0] at;
    logic       accept;

    // Two-flop synchronizer; only sync1 feeds the filter.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= ear_raw ^ INVERT;
            sync1 <= sync0;
        end
    end

    // A level is accepted on the FILT_LEN-th consecutive differing cycle.
    assign accept = (sync1 != ear_out) && (fc == FC_LAST);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fc       <= '0;
            ear_out  <= 1'b0;
            ear_edge <= 1'b0;
        end else begin
            ear_edge <= accept;
            if (sync1 == ear_out) begin
                fc <= '0;
            end else if (fc == FC_LAST) begin
                fc      <= '0;
                ear_out <= ~ear_out;
            end else begin
                fc <= fc + 8'd1;
            end
        end
    end

    // Retriggerable hold timer: reload on each edge, count down to zero.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            at <= '0;
        end else if (accept) begin
            at <= AT_LOAD;
        end else if (at != '0) begin
            at <= at - 20'd1;
        end
    end

    assign activity = (at != '0);

`ifdef EAR_PULSE_STATS_EN
    localparam logic [0:0] ST_NOREF  = 1'b0;
    localparam logic [0:0] ST_TIMING = 1'b1;

    logic [0:0]  state;
    logic [15:0] pc;

    // pc is loaded with 1 on the edge clock, so at the next edge it holds
    // the exact edge-to-edge distance in cycles.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= ST_NOREF;
            pc          <= '0;
            pulse_width <= '0;
            pulse_valid <= 1'b0;
        end else begin
            pulse_valid <= 1'b0;
            if (accept) begin
                // An edge always becomes the new reference, even with clr_stats.
                state <= ST_TIMING;
                pc    <= 16'd1;
                if (state == ST_TIMING && !clr_stats) begin
                    pulse_width <= pc;
                    pulse_valid <= 1'b1;
                end
            end else if (clr_stats) begin
                state <= ST_NOREF;
                pc    <= '0;
            end else if (state == ST_TIMING && pc != 16'hFFFF) begin
                pc <= pc + 16'd1;
            end
        end
    end
`else
    logic unused_clr_stats;
    assign unused_clr_stats = clr_stats;
    assign pulse_width      = '0;
    assign pulse_valid      = 1'b0;
`endif

endmodule
